// File: rtl/fp_mult_result_packer_if.sv
// Result stream bundle: multiplier beats in, packed beats out.
// Ports: result/flags/valid_in/ready_out (input side),
//        data_out/is_status/last_out/valid_out/ready_in (output side),
//        clear_sticky/sticky_flags (software error flags).
interface fp_mult_result_packer_if;
  logic [31:0] result;
  logic        exception;
  logic        overflow;
  logic        underflow;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        is_status;
  logic        last_out;
  logic        valid_out;
  logic        ready_in;
  logic        clear_sticky;
  logic [2:0]  sticky_flags;

  modport slave (
    input  result,
    input  exception,
    input  overflow,
    input  underflow,
    input  valid_in,
    input  ready_in,
    input  clear_sticky,
    output ready_out,
    output data_out,
    output is_status,
    output last_out,
    output valid_out,
    output sticky_flags
  );

  modport master (
    output result,
    output exception,
    output overflow,
    output underflow,
    output valid_in,
    output ready_in,
    output clear_sticky,
    input  ready_out,
    input  data_out,
    input  is_status,
    input  last_out,
    input  valid_out,
    input  sticky_flags
  );
endinterface

// File: rtl/fp_mult_result_packer.sv
// Packs FP multiplier results into groups of GROUP plus one status beat.
// Ports: clk, reset (async, active-low), bus (slave side of result stream).
module fp_mult_result_packer #(
  parameter int GROUP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  fp_mult_result_packer_if.slave  bus
);
  localparam int IW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(GROUP - 1);

  typedef struct packed {
    logic [31:0] data;
    logic        exc;
    logic        ovf;
    logic        unf;
  } beat_t;

  typedef enum logic {
    STREAM = 1'b0,
    STATUS = 1'b1
  } state_t;

  beat_t       fifo_q [2];
  beat_t       head;
  beat_t       in_beat;
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  occ_q;
  logic [1:0]  occ_d;
  logic        rdy_q;
  logic        push;
  logic        pop;
  logic        empty;

  state_t      state_q;
  state_t      state_d;
  logic        load;
  logic        emit_beat;
  logic        emit_status;
  logic        drop;

  logic [IW-1:0] idx_q;
  logic [7:0]  seq_q;
  logic [7:0]  exc_q;
  logic [7:0]  ovf_q;
  logic [7:0]  unf_q;

  logic [31:0] data_q;
  logic        stat_q;
  logic        last_q;
  logic        vld_q;
  logic [2:0]  sticky_q;

  // ---------------- input skid fifo ----------------
  assign in_beat = '{
    data: bus.result,
    exc:  bus.exception,
    ovf:  bus.overflow,
    unf:  bus.underflow
  };

  assign push  = bus.valid_in && rdy_q;
  assign empty = (occ_q == 2'd0);
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      rdy_q     <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= in_beat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
      // Registered from next occupancy so the pin never
      // advertises space the fifo will not have.
      rdy_q <= (occ_d < 2'd2);
    end
  end

  // ---------------- fsm ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STREAM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STREAM: begin
        if (emit_beat && (idx_q == LAST_IDX)) begin
          state_d = STATUS;
        end
      end
      STATUS: begin
        if (emit_status) begin
          state_d = STREAM;
        end
      end
      default: state_d = STREAM;
    endcase
  end

  always_comb begin
    load        = !vld_q || bus.ready_in;
    pop         = 1'b0;
    emit_beat   = 1'b0;
    emit_status = 1'b0;
    drop        = 1'b0;
    unique case (state_q)
      STREAM: begin
        if (load) begin
          if (!empty) begin
            pop       = 1'b1;
            emit_beat = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      STATUS: begin
        emit_status = load;
      end
      default: begin
        drop = load;
      end
    endcase
  end

  // ---------------- group counters ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      seq_q <= 8'd0;
      exc_q <= 8'd0;
      ovf_q <= 8'd0;
      unf_q <= 8'd0;
    end else begin
      unique case (1'b1)
        emit_beat: begin
          idx_q <= idx_q + IW'(1);
          exc_q <= exc_q + {7'd0, head.exc};
          ovf_q <= ovf_q + {7'd0, head.ovf};
          unf_q <= unf_q + {7'd0, head.unf};
        end
        emit_status: begin
          idx_q <= '0;
          exc_q <= 8'd0;
          ovf_q <= 8'd0;
          unf_q <= 8'd0;
          seq_q <= seq_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= 32'd0;
      stat_q <= 1'b0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        emit_beat: begin
          data_q <= head.data;
          stat_q <= 1'b0;
          last_q <= 1'b0;
          vld_q  <= 1'b1;
        end
        emit_status: begin
          data_q <= {seq_q, exc_q, ovf_q, unf_q};
          stat_q <= 1'b1;
          last_q <= 1'b1;
          vld_q  <= 1'b1;
        end
        drop: begin
          vld_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  // A flag arriving with the clear request survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= (bus.clear_sticky ? 3'b000 : sticky_q)
                | (push ? {in_beat.exc, in_beat.ovf, in_beat.unf}
                        : 3'b000);
    end
  end

  assign bus.ready_out    = rdy_q;
  assign bus.data_out     = data_q;
  assign bus.is_status    = stat_q;
  assign bus.last_out     = last_q;
  assign bus.valid_out    = vld_q;
  assign bus.sticky_flags = sticky_q;
endmodule

// File: tb/tb_fp_mult_result_packer.sv
// Testbench for fp_mult_result_packer.
// Reference model: queue of expected output beats built from accepted inputs.
module tb_fp_mult_result_packer;
  localparam int GROUP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_mult_result_packer_if bus ();

  fp_mult_result_packer #(.GROUP(GROUP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q [$];
  int          m_n;
  logic [7:0]  m_seq, m_e, m_o, m_u;
  logic [2:0]  m_sticky;

  logic        last_push;
  logic [31:0] last_status;
  int          status_cnt = 0;
  logic [7:0]  prev_seq = 8'd0;
  logic        wrapped = 1'b0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_n = 0;
    m_seq = 8'd0;
    m_e = 8'd0;
    m_o = 8'd0;
    m_u = 8'd0;
    m_sticky = 3'b000;
  endtask

  task automatic model_push(logic [31:0] d, logic [2:0] fl);
    exp_q.push_back({2'b00, d});
    m_e = m_e + 8'(fl[2]);
    m_o = m_o + 8'(fl[1]);
    m_u = m_u + 8'(fl[0]);
    m_n++;
    if (m_n == GROUP) begin
      exp_q.push_back({2'b11, m_seq, m_e, m_o, m_u});
      m_seq = m_seq + 8'd1;
      m_e = 8'd0;
      m_o = 8'd0;
      m_u = 8'd0;
      m_n = 0;
    end
  endtask

  // One clock: observe handshakes just after the negedge, advance to next negedge.
  task automatic cycle();
    logic [2:0]  fl, nxt;
    logic        acc, hold;
    logic [33:0] got, want;
    logic [34:0] held;
    logic [7:0]  sq;
    #1;
    last_push = bus.valid_in && bus.ready_out;
    acc  = bus.valid_out && bus.ready_in;
    hold = bus.valid_out && !bus.ready_in;
    held = {bus.valid_out, bus.is_status, bus.last_out, bus.data_out};
    fl   = {bus.exception, bus.overflow, bus.underflow};
    if (acc) begin
      got = {bus.is_status, bus.last_out, bus.data_out};
      if (exp_q.size() == 0) begin
        chk("extra_beat", 64'(exp_q.size()), 64'(1));
      end else begin
        want = exp_q.pop_front();
        chk("out_beat", 64'(got), 64'(want));
      end
      if (bus.is_status) begin
        sq = bus.data_out[31:24];
        if (status_cnt > 0 && prev_seq == 8'hFF && sq == 8'h00)
          wrapped = 1'b1;
        prev_seq = sq;
        status_cnt++;
        last_status = bus.data_out;
      end
    end
    nxt = (bus.clear_sticky ? 3'b000 : m_sticky)
        | (last_push ? fl : 3'b000);
    if (last_push) model_push(bus.result, fl);
    @(posedge clk);
    @(negedge clk);
    m_sticky = nxt;
    chk("sticky", 64'(bus.sticky_flags), 64'(m_sticky));
    if (hold)
      chk("hold", 64'({bus.valid_out, bus.is_status,
                       bus.last_out, bus.data_out}), 64'(held));
  endtask

  task automatic send(logic [31:0] d, logic [2:0] fl);
    bus.result = d;
    {bus.exception, bus.overflow, bus.underflow} = fl;
    bus.valid_in = 1'b1;
    last_push = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_push) break;
    end
    chk("send_accepted", 64'(last_push), 64'(1));
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && !bus.valid_out) break;
      cycle();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bus.result = 32'd0;
    bus.exception = 1'b0;
    bus.overflow = 1'b0;
    bus.underflow = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.clear_sticky = 1'b0;
    last_status = 32'hFFFF_FFFF;
    model_reset();
    reset = 1'b0;

    // reset state
    #12;
    chk("rst_outputs", 64'({bus.ready_out, bus.data_out, bus.is_status,
                            bus.last_out, bus.valid_out, bus.sticky_flags}),
        64'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rdy_before_edge", 64'(bus.ready_out), 64'(0));
    @(negedge clk);
    chk("rdy_after_edge", 64'(bus.ready_out), 64'(1));

    // clean group with latency probe
    bus.ready_in = 1'b1;
    send(32'h3F80_0000, 3'b000);
    chk("lat_edge_t", 64'(bus.valid_out), 64'(0));
    send(32'h4000_0000, 3'b000);
    chk("lat_edge_t1", 64'({bus.valid_out, bus.data_out}),
        64'({1'b1, 32'h3F80_0000}));
    send(32'h4040_0000, 3'b000);
    send(32'h4080_0000, 3'b000);
    drain();
    chk("clean_status", 64'(last_status), 64'(32'h0000_0000));

    // second group: sequence number advances
    for (int i = 0; i < GROUP; i++) send($urandom, 3'b000);
    drain();
    chk("seq1_status", 64'(last_status), 64'(32'h0100_0000));

    // flag counting
    send($urandom, 3'b100);
    send($urandom, 3'b010);
    send($urandom, 3'b001);
    send($urandom, 3'b010);
    drain();
    chk("flag_counts", 64'(last_status[23:0]), 64'(24'h01_02_01));
    chk("flag_seq", 64'(last_status[31:24]), 64'(8'h02));
    chk("sticky_all", 64'(bus.sticky_flags), 64'(3'b111));
    bus.clear_sticky = 1'b1;
    cycle();
    bus.clear_sticky = 1'b0;
    chk("sticky_clr", 64'(bus.sticky_flags), 64'(3'b000));

    // backpressure: 10 stalled cycles with continuous input
    bus.ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.result = $urandom;
      {bus.exception, bus.overflow, bus.underflow} = 3'b000;
      bus.valid_in = 1'b1;
      cycle();
    end
    chk("bp_ready_low", 64'(bus.ready_out), 64'(0));
    chk("bp_valid_held", 64'(bus.valid_out), 64'(1));
    drain();

    // randomized run through the sequence wrap
    for (int i = 0; i < 8000 && status_cnt < 262; i++) begin
      bus.result = $urandom;
      bus.exception = ($urandom_range(0, 3) == 0);
      bus.overflow = ($urandom_range(0, 3) == 0);
      bus.underflow = ($urandom_range(0, 3) == 0);
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.ready_in = ($urandom_range(0, 3) != 0);
      bus.clear_sticky = ($urandom_range(0, 15) == 0);
      cycle();
    end
    bus.clear_sticky = 1'b0;
    chk("wrap_groups", 64'(status_cnt >= 262), 64'(1));
    chk("seq_wrap", 64'(wrapped), 64'(1));
    drain();

    // reset mid-group after 2 results
    for (int k = 0; k < 20 && m_n != 2; k++) send($urandom, 3'b000);
    chk("pre_reset_pos", 64'(m_n), 64'(2));
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst", 64'({bus.ready_out, bus.data_out, bus.is_status,
                          bus.last_out, bus.valid_out, bus.sticky_flags}),
        64'(0));
    model_reset();
    #9;
    reset = 1'b1;
    @(negedge clk);
    last_status = 32'hFFFF_FFFF;
    bus.ready_in = 1'b1;
    for (int i = 0; i < GROUP; i++) send($urandom, 3'b000);
    drain();
    chk("post_rst_status", 64'(last_status), 64'(32'h0000_0000));

    // clear and set on the same edge
    send($urandom, 3'b100);
    chk("sticky_exc", 64'(bus.sticky_flags), 64'(3'b100));
    bus.clear_sticky = 1'b1;
    send($urandom, 3'b010);
    bus.clear_sticky = 1'b0;
    chk("clr_set", 64'(bus.sticky_flags), 64'(3'b010));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
